// File: rtl/gfx_pkg.sv
// Shared types and constants for the viewport triangle assembler.
// Holds screen coordinate width, Q1.7 constants, vertex struct and FSM states.
package gfx_pkg;

    localparam int CORDW = 16;
    localparam int Q_FRAC = 7;
    localparam logic [7:0] Q_ONE = 8'h80;

    typedef struct packed {
        logic [CORDW-1:0] x;
        logic [CORDW-1:0] y;
    } screen_vert_t;

    typedef enum logic [1:0] {
        V0,
        V1,
        V2,
        FULL
    } asm_state_t;

    // Anything above 1.0 is pinned to 1.0; negatives do not exist in this format.
    function automatic logic [7:0] q_clamp(input logic [7:0] q);
        return (q > Q_ONE) ? Q_ONE : q;
    endfunction

endpackage

// File: rtl/viewport_tri_assembler_if.sv
// Vertex-in / triangle-out handshake bundle of the viewport triangle assembler.
// slave: assembler view (vertex sink, triangle source); master: the opposite side.
interface viewport_tri_assembler_if;
    import gfx_pkg::*;

    logic             io_in_valid;
    logic             io_in_ready;
    logic [7:0]       io_in_x;
    logic [7:0]       io_in_y;
    logic             io_tri_valid;
    logic             io_tri_ready;
    logic [CORDW-1:0] io_tri_x0;
    logic [CORDW-1:0] io_tri_y0;
    logic [CORDW-1:0] io_tri_x1;
    logic [CORDW-1:0] io_tri_y1;
    logic [CORDW-1:0] io_tri_x2;
    logic [CORDW-1:0] io_tri_y2;
    logic             io_tri_degenerate;
    logic [CORDW-1:0] io_tri_count;

    modport slave (
        input  io_in_valid, io_in_x, io_in_y, io_tri_ready,
        output io_in_ready, io_tri_valid,
        output io_tri_x0, io_tri_y0, io_tri_x1, io_tri_y1,
        output io_tri_x2, io_tri_y2, io_tri_degenerate, io_tri_count
    );

    modport master (
        output io_in_valid, io_in_x, io_in_y, io_tri_ready,
        input  io_in_ready, io_tri_valid,
        input  io_tri_x0, io_tri_y0, io_tri_x1, io_tri_y1,
        input  io_tri_x2, io_tri_y2, io_tri_degenerate, io_tri_count
    );

endinterface

// File: rtl/viewport_scale.sv
// Combinational Q1.7 -> screen coordinate: clamp to [0,1.0], scale by RES-1, round.
// Ports: q (8-bit unsigned Q1.7 in), s (CORDW-bit screen coordinate out).
module viewport_scale
    import gfx_pkg::*;
#(
    parameter int RES = 640
) (
    input  logic [7:0]       q,
    output logic [CORDW-1:0] s
);

    localparam logic [23:0] MUL = 24'(RES - 1);
    localparam logic [23:0] RND = 24'(1 << (Q_FRAC - 1));

    logic [23:0] prod;

    assign prod = {16'd0, q_clamp(q)} * MUL + RND;
    assign s    = CORDW'(prod >> Q_FRAC);

endmodule

// File: rtl/viewport_tri_assembler.sv
// Registers incoming Q1.7 vertices, scales them to screen space and groups
// every three into a triangle for the rasteriser; flags degenerates, counts hand-offs.
// Ports: clock, io_aresetn (sync active-low), io_flush, bus (vertex in / triangle out).
module viewport_tri_assembler
    import gfx_pkg::*;
#(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input logic                      clock,
    input logic                      io_aresetn,
    input logic                      io_flush,
    viewport_tri_assembler_if.slave  bus
);

    asm_state_t       state;
    asm_state_t       state_nxt;
    logic             s1_valid;
    logic [7:0]       s1_x;
    logic [7:0]       s1_y;
    logic [CORDW-1:0] sx;
    logic [CORDW-1:0] sy;
    screen_vert_t     s1_vert;
    screen_vert_t     slot0;
    screen_vert_t     slot1;
    screen_vert_t     slot2;
    logic [CORDW-1:0] count;
    logic             full;
    logic             can_adv;
    logic             s1_adv;
    logic             tri_fire;
    logic             in_ready;
    logic             in_fire;
    logic             degen;

    viewport_scale #(.RES(H_RES)) u_sx (.q(s1_x), .s(sx));
    viewport_scale #(.RES(V_RES)) u_sy (.q(s1_y), .s(sy));

    assign s1_vert = '{x: sx, y: sy};

    // Flush masks every handshake in its cycle.
    always_comb begin
        full     = (state == FULL);
        can_adv  = !full || bus.io_tri_ready;
        s1_adv   = s1_valid && can_adv && !io_flush;
        tri_fire = full && bus.io_tri_ready && !io_flush;
        in_ready = io_aresetn && !io_flush && (!s1_valid || can_adv);
        in_fire  = bus.io_in_valid && in_ready;
        degen    = (slot0 == slot1) || (slot1 == slot2) || (slot0 == slot2);
    end

    always_comb begin
        state_nxt = state;
        if (io_flush) begin
            state_nxt = V0;
        end else begin
            unique case (state)
                V0:   if (s1_adv) state_nxt = V1;
                V1:   if (s1_adv) state_nxt = V2;
                V2:   if (s1_adv) state_nxt = FULL;
                FULL: if (tri_fire) state_nxt = s1_valid ? V1 : V0;
                default: state_nxt = V0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!io_aresetn) begin
            state <= V0;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!io_aresetn) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            slot0    <= '0;
            slot1    <= '0;
            slot2    <= '0;
            count    <= '0;
        end else begin
            if (io_flush) begin
                s1_valid <= 1'b0;
            end else if (in_fire) begin
                s1_valid <= 1'b1;
                s1_x     <= q_clamp(bus.io_in_x);
                s1_y     <= q_clamp(bus.io_in_y);
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            // Advancing out of FULL means the triangle leaves this cycle,
            // so the new vertex starts the next one in slot 0.
            if (s1_adv) begin
                unique case (state)
                    V0, FULL: slot0 <= s1_vert;
                    V1:       slot1 <= s1_vert;
                    V2:       slot2 <= s1_vert;
                endcase
            end
            if (tri_fire) begin
                count <= count + CORDW'(1);
            end
        end
    end

    assign bus.io_in_ready       = in_ready;
    assign bus.io_tri_valid      = io_aresetn && full;
    assign bus.io_tri_x0         = io_aresetn ? slot0.x : '0;
    assign bus.io_tri_y0         = io_aresetn ? slot0.y : '0;
    assign bus.io_tri_x1         = io_aresetn ? slot1.x : '0;
    assign bus.io_tri_y1         = io_aresetn ? slot1.y : '0;
    assign bus.io_tri_x2         = io_aresetn ? slot2.x : '0;
    assign bus.io_tri_y2         = io_aresetn ? slot2.y : '0;
    assign bus.io_tri_degenerate = io_aresetn && full && degen;
    assign bus.io_tri_count      = io_aresetn ? count : '0;

endmodule

// File: tb/tb_viewport_tri_assembler.sv
// Scoreboard bench for viewport_tri_assembler: driver feeds vertices into a
// reference model, a monitor pops expected triangles on every hand-off.
module tb_viewport_tri_assembler;
    import gfx_pkg::*;

    typedef struct {
        int x[3];
        int y[3];
        bit deg;
    } tri_t;

    logic clock = 1'b0;
    logic io_aresetn = 1'b0;
    logic io_flush = 1'b0;

    always #5 clock = ~clock;

    viewport_tri_assembler_if bus ();

    viewport_tri_assembler dut (
        .clock      (clock),
        .io_aresetn (io_aresetn),
        .io_flush   (io_flush),
        .bus        (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 1;
    int n_hand = 0;
    int n_acc = 0;
    int last_acc_cyc = 0;
    int last_tri_cyc = 0;
    int px[$];
    int py[$];
    tri_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: clamp to 1.0, scale to RES-1 with round-half-up.
    function automatic int scl(input int c, input int res);
        int cc;
        cc = (c > 128) ? 128 : c;
        return (cc * (res - 1) + 64) / 128;
    endfunction

    function automatic void model_accept(input int x, input int y);
        tri_t t;
        px.push_back(scl(x, 640));
        py.push_back(scl(y, 480));
        if (px.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                t.x[i] = px[i];
                t.y[i] = py[i];
            end
            t.deg = 0;
            for (int i = 0; i < 3; i++)
                for (int j = i + 1; j < 3; j++)
                    if (t.x[i] == t.x[j] && t.y[i] == t.y[j]) t.deg = 1;
            exp_q.push_back(t);
            px.delete();
            py.delete();
        end
    endfunction

    always begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0: bus.io_tri_ready = 1'b0;
            1: bus.io_tri_ready = 1'b1;
            default: bus.io_tri_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a handshake is seen at the negedge before the edge that takes it.
    always @(negedge clock) begin
        tri_t t;
        if (io_aresetn && bus.io_tri_valid && bus.io_tri_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tri: got triangle, expected none");
            end else begin
                t = exp_q.pop_front();
                chk("x0", int'(bus.io_tri_x0), t.x[0]);
                chk("y0", int'(bus.io_tri_y0), t.y[0]);
                chk("x1", int'(bus.io_tri_x1), t.x[1]);
                chk("y1", int'(bus.io_tri_y1), t.y[1]);
                chk("x2", int'(bus.io_tri_x2), t.x[2]);
                chk("y2", int'(bus.io_tri_y2), t.y[2]);
                chk("degenerate", int'(bus.io_tri_degenerate), int'(t.deg));
                chk("count_at_handoff", int'(bus.io_tri_count), n_hand);
            end
            n_hand++;
            last_tri_cyc = cyc;
        end
    end

    // Held triangle must not change while the rasteriser stalls.
    logic stall_prev = 1'b0;
    logic [CORDW-1:0] hold [6];
    always @(negedge clock) begin
        if (stall_prev && bus.io_tri_valid) begin
            chk("hold_x0", int'(bus.io_tri_x0), int'(hold[0]));
            chk("hold_y0", int'(bus.io_tri_y0), int'(hold[1]));
            chk("hold_x2", int'(bus.io_tri_x2), int'(hold[4]));
            chk("hold_y2", int'(bus.io_tri_y2), int'(hold[5]));
        end
        stall_prev = io_aresetn && bus.io_tri_valid && !bus.io_tri_ready;
        hold[0] = bus.io_tri_x0;
        hold[1] = bus.io_tri_y0;
        hold[2] = bus.io_tri_x1;
        hold[3] = bus.io_tri_y1;
        hold[4] = bus.io_tri_x2;
        hold[5] = bus.io_tri_y2;
    end

    // Called and returns at posedge+1.
    task automatic send(input int x, input int y);
        int t;
        t = 0;
        bus.io_in_valid = 1'b1;
        bus.io_in_x = x[7:0];
        bus.io_in_y = y[7:0];
        @(negedge clock);
        while (!bus.io_in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!bus.io_in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no io_in_ready, expected ready");
        end else begin
            model_accept(x, y);
            n_acc++;
            last_acc_cyc = cyc;
        end
        @(posedge clock);
        #1;
        bus.io_in_valid = 1'b0;
        bus.io_in_x = 8'($urandom);
        bus.io_in_y = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drain(input int bound);
        int t;
        t = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || bus.io_tri_valid) && t < bound) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0 || bus.io_tri_valid) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
        @(posedge clock);
        #1;
    endtask

    bit stall_done;

    initial begin
        int base;
        bus.io_in_valid = 1'b1;
        bus.io_in_x = 8'h40;
        bus.io_in_y = 8'h40;
        bus.io_tri_ready = 1'b1;

        repeat (10) begin
            @(negedge clock);
            chk("rst_in_ready", int'(bus.io_in_ready), 0);
            chk("rst_tri_valid", int'(bus.io_tri_valid), 0);
            chk("rst_count", int'(bus.io_tri_count), 0);
            chk("rst_x0", int'(bus.io_tri_x0), 0);
        end
        @(posedge clock);
        #1;
        bus.io_in_valid = 1'b0;
        io_aresetn = 1'b1;
        idle(5);
        @(negedge clock);
        chk("post_rst_tri_valid", int'(bus.io_tri_valid), 0);
        chk("post_rst_in_ready", int'(bus.io_in_ready), 1);
        @(posedge clock);
        #1;

        // Basic triangle, back-to-back, ready high.
        rdy_mode = 1;
        send(8'h40, 8'h40);
        send(8'h80, 8'h00);
        send(8'h00, 8'h80);
        drain(50);
        chk("latency", last_tri_cyc - last_acc_cyc, 2);
        chk("count_1", int'(bus.io_tri_count), 1);

        // Clamp and rounding.
        send(8'hFF, 8'hC0);
        send(8'h40, 8'h60);
        send(8'h01, 8'h01);
        drain(50);

        // Stall: six vertices offered while rasteriser holds off.
        rdy_mode = 0;
        idle(1);
        base = n_acc;
        stall_done = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send($urandom_range(0, 255), $urandom_range(0, 255));
                stall_done = 1;
            end
        join_none
        repeat (12) @(negedge clock);
        chk("stall_in_ready", int'(bus.io_in_ready), 0);
        chk("stall_tri_valid", int'(bus.io_tri_valid), 1);
        chk("stall_accepted", n_acc - base, 4);
        rdy_mode = 1;
        for (int t = 0; t < 200 && !stall_done; t++) @(negedge clock);
        chk("stall_driver_done", int'(stall_done), 1);
        @(posedge clock);
        #1;
        drain(50);
        chk("count_after_stall", int'(bus.io_tri_count), 4);

        // Flush a partial triangle.
        base = n_hand;
        send(8'h10, 8'h20);
        send(8'h30, 8'h40);
        io_flush = 1'b1;
        @(negedge clock);
        chk("flush_in_ready", int'(bus.io_in_ready), 0);
        @(posedge clock);
        #1;
        io_flush = 1'b0;
        px.delete();
        py.delete();
        send(8'h05, 8'h06);
        send(8'h50, 8'h07);
        send(8'h70, 8'h7F);
        drain(50);
        chk("flush_count_delta", int'(bus.io_tri_count) - base, 1);

        // Degenerate triangle.
        send(8'h40, 8'h40);
        send(8'h40, 8'h40);
        send(8'h80, 8'h80);
        drain(50);

        // Random traffic with random ready.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        drain(500);
        chk("count_random", int'(bus.io_tri_count), n_hand);

        // Reset in the middle of a triangle.
        rdy_mode = 1;
        send(8'h22, 8'h33);
        io_aresetn = 1'b0;
        px.delete();
        py.delete();
        n_hand = 0;
        idle(2);
        @(negedge clock);
        chk("midrst_count", int'(bus.io_tri_count), 0);
        chk("midrst_tri_valid", int'(bus.io_tri_valid), 0);
        @(posedge clock);
        #1;
        io_aresetn = 1'b1;
        send(8'h11, 8'h12);
        send(8'h13, 8'h14);
        send(8'h80, 8'h15);
        drain(50);
        chk("midrst_count_after", int'(bus.io_tri_count), 1);
        chk("leftover", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
